dsi_tx_line_scheduler: RTL and testbench
========================================

# dsi_tx_line_scheduler

Sequences one DSI video frame at a time: emits the vertical and horizontal sync short packets, the per-line RGB888 long-packet header and the pixel payload drawn from the pixel buffer FIFO. It enforces the programmed blanking between lines. It sits in the `clk_phy` domain between the pixel buffer output (`fifo_data`/`fifo_line_ready`/`fifo_read_ack`) and the DSI packet assembler. Frame geometry is latched at every frame start, so register writes never tear a frame.

## Interface
- `LINE_CNT_W`, 12: width of the per-region line configuration ports.
- `HBLANK_W`, 12: width of the blanking cycle counter.
- `clk`  in  1  clock; the packet/PHY-side clock. This is the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run frames continuously while high.
- `cfg_vsa_lines`  in  LINE_CNT_W  vertical sync lines; a value of 0 is treated as 1.
- `cfg_vbp_lines`, `cfg_vfp_lines`  in  LINE_CNT_W  back and front porch lines.
- `cfg_vact_lines`  in  LINE_CNT_W  active lines.
- `cfg_line_words`  in  10  32-bit payload words per active line.
- `cfg_hblank_cycles`  in  HBLANK_W  idle cycles after each line; minimum effective value is 1.
- `fifo_data`  in  32  show-ahead head word of the pixel buffer.
- `fifo_not_empty`  in  1  head word is valid.
- `fifo_line_ready`  in  1  at least one full line is buffered.
- `fifo_read_ack`  out  1  pops the head word.
- `pkt_valid`/`pkt_ready`  out/in  1  packet header handshake.
- `pkt_dt`  out  6  DSI data type.
- `pkt_wc`  out  16  word count for long packets; 0 for short packets.
- `pkt_long`  out  1  long packet; a payload follows.
- `pld_data`  out  32  payload word.
- `pld_valid`/`pld_ready`  out/in  1  payload handshake.
- `pld_last`  out  1  final word of the line.
- `frame_active`  out  1  high from frame start until `FRAME_END`.
- `underflow`  out  1  sticky; cleared only by reset.

## Operation
- States: `IDLE`, `FRAME_START`, `WAIT_LINE`, `SYNC_PKT`, `LONG_HDR`, `PAYLOAD`, `HBLANK`, `FRAME_END`.
- `IDLE` → `FRAME_START` when `enable` is high.
- `FRAME_START`:
  - latches all `cfg_*` inputs;
  - clears `line_cnt` (14-bit; total = vsa+vbp+vact+vfp);
  - goes to `SYNC_PKT`.
- Line regions, in order: VSA, VBP, ACT, VFP.
- Before the `SYNC_PKT` of an ACT line the FSM enters `WAIT_LINE` and stays until `fifo_line_ready` is high.
- `SYNC_PKT` issues a short packet:
  - `pkt_dt` = 0x01 (VSS) on line 0;
  - 0x21 (HSS) on every other line;
  - `pkt_wc` = 0, `pkt_long` = 0.
- After `SYNC_PKT`:
  - ACT lines go to `LONG_HDR`: `pkt_dt` = 0x3E, `pkt_wc` = `cfg_line_words`×4, `pkt_long` = 1;
  - all other lines go to `HBLANK`.
- `PAYLOAD`:
  - `pld_valid` = `fifo_not_empty`;
  - `pld_data` = `fifo_data`;
  - `fifo_read_ack` = `pld_valid` & `pld_ready`;
  - `pld_last` is high on word `cfg_line_words`−1.
  - The last accepted word moves the FSM to `HBLANK`.
  - If `cfg_line_words` = 0, `LONG_HDR` goes straight to `HBLANK` with WC = 0 and no payload.
- Underflow: if `fifo_not_empty` is low while in `PAYLOAD`, set `underflow`. `PAYLOAD` still stalls; no word is skipped or invented.
- `HBLANK` counts max(1, `cfg_hblank_cycles`) cycles, then:
  - increments `line_cnt`;
  - goes to `FRAME_END` after the last line, otherwise to the next line.
- `FRAME_END` goes to `FRAME_START` if `enable` is high, else to `IDLE`.
- Dropping `enable` mid-frame completes the frame.
- `fifo_read_ack` is never asserted outside `PAYLOAD`.

## Timing
- Reset values:
  - FSM in `IDLE`;
  - `pkt_valid`, `pkt_long`, `pld_valid`, `pld_last`, `fifo_read_ack`, `frame_active`, `underflow` = 0;
  - `pkt_dt` = 0, `pkt_wc` = 0, `pld_data` = 0.
- `pkt_*` are registered and asserted the cycle after state entry.
- `pkt_*` hold stable until the cycle `pkt_valid` & `pkt_ready` are both high; the next state is entered the following cycle.
- `pld_*` are combinational from the FIFO head, giving zero-latency pops. This is legal because the buffer is show-ahead.
- Latency from `enable` rising to the first `pkt_valid` is 3 cycles (`IDLE` → `FRAME_START` → `SYNC_PKT` + register).
- Asynchronous reset mid-line drops the packet without a trailer. The assembler is reset together with this block.

## Structure
- Shared package `dsi_tx_pkg` holds:
  - data-type constants `DT_VSS`=0x01, `DT_HSS`=0x21, `DT_RGB888`=0x3E;
  - the FSM state encoding.
- No sub-module is needed. A single FSM plus `line_cnt`, `word_cnt` and `hblank_cnt` counters covers the block.

## Test plan
- Geometry vsa=1, vbp=1, vact=2, vfp=1, words=4, hblank=3, FIFO pre-filled, `pkt_ready` = `pld_ready` = 1. Required packet sequence: VSS, HSS, HSS, 0x3E(WC=16)+4 words, HSS, 0x3E+4 words, HSS. Each line is followed by 3 idle cycles, and the bench sees exactly 8 `fifo_read_ack` pulses.
- `fifo_line_ready` held low for 20 cycles on the first ACT line → no HSS is issued until it rises.
- `pkt_ready` low for 5 cycles → `pkt_dt`/`pkt_wc` stay stable and nothing is dropped.
- `fifo_not_empty` drops for 3 cycles mid-payload → `underflow` = 1, stays 1, and the payload resumes with the word sequence intact.
- `enable` deasserted on line 2 → the frame completes through the VFP line, `frame_active` falls, and the FSM returns to `IDLE`.
- Zero cases vsa=0, words=0, hblank=0 → one VSS line, an RGB888 header with WC=0 and no `pld_valid`, and 1-cycle blanking.

Source files
------------

// File: rtl/dsi_tx_pkg.sv
// Shared DSI TX definitions: packet data types and the line scheduler state encoding.
package dsi_tx_pkg;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef enum logic [2:0] {
        IDLE,
        FRAME_START,
        WAIT_LINE,
        SYNC_PKT,
        LONG_HDR,
        PAYLOAD,
        HBLANK,
        FRAME_END
    } sched_state_t;

endpackage

// File: rtl/dsi_tx_line_scheduler.sv
// Per-frame DSI video line scheduler: sync short packets, RGB888 line headers,
// pixel payload from a show-ahead FIFO, and programmed horizontal blanking.
//
// state       | meaning
// IDLE        | no frame in progress
// FRAME_START | latch geometry, clear line counter
// WAIT_LINE   | hold an active line until a full line is buffered
// SYNC_PKT    | VSS on line 0, HSS on every other line
// LONG_HDR    | RGB888 long packet header
// PAYLOAD     | stream cfg_line_words words from the FIFO
// HBLANK      | idle cycles after each line
// FRAME_END   | frame done; restart or go idle
module dsi_tx_line_scheduler
    import dsi_tx_pkg::*;
#(
    parameter int LINE_CNT_W = 12,
    parameter int HBLANK_W   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [LINE_CNT_W-1:0] cfg_vsa_lines,
    input  logic [LINE_CNT_W-1:0] cfg_vbp_lines,
    input  logic [LINE_CNT_W-1:0] cfg_vfp_lines,
    input  logic [LINE_CNT_W-1:0] cfg_vact_lines,
    input  logic [9:0]            cfg_line_words,
    input  logic [HBLANK_W-1:0]   cfg_hblank_cycles,
    input  logic [31:0]           fifo_data,
    input  logic                  fifo_not_empty,
    input  logic                  fifo_line_ready,
    output logic                  fifo_read_ack,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [5:0]            pkt_dt,
    output logic [15:0]           pkt_wc,
    output logic                  pkt_long,
    output logic [31:0]           pld_data,
    output logic                  pld_valid,
    input  logic                  pld_ready,
    output logic                  pld_last,
    output logic                  frame_active,
    output logic                  underflow
);

    localparam int LINE_W = 14;

    sched_state_t state, state_nxt;

    logic [LINE_W-1:0]   line_cnt;
    logic [LINE_W-1:0]   act_start_q, act_end_q, total_q;
    logic [LINE_W-1:0]   vsa_eff, cfg_act_start, cfg_act_end, cfg_total;
    logic [9:0]          word_cnt, words_q;
    logic [HBLANK_W-1:0] hblank_cnt, hblank_q, hblank_load;

    logic pkt_hs, pld_hs;
    logic last_word, last_line, line_is_act, next_is_act, hblank_done;
    logic [LINE_W-1:0] next_line;

    assign vsa_eff       = (cfg_vsa_lines == '0) ? LINE_W'(1) : LINE_W'(cfg_vsa_lines);
    assign cfg_act_start = vsa_eff + LINE_W'(cfg_vbp_lines);
    assign cfg_act_end   = cfg_act_start + LINE_W'(cfg_vact_lines);
    assign cfg_total     = cfg_act_end + LINE_W'(cfg_vfp_lines);

    assign pkt_hs      = pkt_valid & pkt_ready;
    assign pld_hs      = pld_valid & pld_ready;
    assign last_word   = (word_cnt == words_q - 10'd1);
    assign last_line   = (line_cnt == total_q - LINE_W'(1));
    assign next_line   = line_cnt + LINE_W'(1);
    assign line_is_act = (line_cnt >= act_start_q) && (line_cnt < act_end_q);
    assign next_is_act = (next_line >= act_start_q) && (next_line < act_end_q);
    assign hblank_done = (hblank_cnt == '0);
    // Counter holds remaining cycles after the current one; zero programs as one cycle.
    assign hblank_load = (hblank_q == '0) ? '0 : hblank_q - HBLANK_W'(1);

    // Payload is combinational from the show-ahead head word for zero-latency pops.
    assign pld_valid     = (state == PAYLOAD) && fifo_not_empty;
    assign pld_data      = (state == PAYLOAD) ? fifo_data : '0;
    assign pld_last      = (state == PAYLOAD) && last_word;
    assign fifo_read_ack = pld_valid && pld_ready;
    assign frame_active  = (state != IDLE) && (state != FRAME_END);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (enable) state_nxt = FRAME_START;
            FRAME_START: state_nxt = SYNC_PKT;
            WAIT_LINE:   if (fifo_line_ready) state_nxt = SYNC_PKT;
            SYNC_PKT:    if (pkt_hs) state_nxt = line_is_act ? LONG_HDR : HBLANK;
            LONG_HDR:    if (pkt_hs) state_nxt = (words_q == '0) ? HBLANK : PAYLOAD;
            PAYLOAD:     if (pld_hs && last_word) state_nxt = HBLANK;
            HBLANK: begin
                if (hblank_done) begin
                    if (last_line)        state_nxt = FRAME_END;
                    else if (next_is_act) state_nxt = WAIT_LINE;
                    else                  state_nxt = SYNC_PKT;
                end
            end
            FRAME_END:   state_nxt = enable ? FRAME_START : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            pkt_dt    <= '0;
            pkt_wc    <= '0;
            pkt_long  <= 1'b0;
        end else if ((state == SYNC_PKT || state == LONG_HDR) && !pkt_valid) begin
            pkt_valid <= 1'b1;
            if (state == SYNC_PKT) begin
                pkt_dt   <= (line_cnt == '0) ? DT_VSS : DT_HSS;
                pkt_wc   <= '0;
                pkt_long <= 1'b0;
            end else begin
                pkt_dt   <= DT_RGB888;
                pkt_wc   <= {4'b0000, words_q, 2'b00};
                pkt_long <= 1'b1;
            end
        end else if (pkt_hs) begin
            pkt_valid <= 1'b0;
            pkt_dt    <= '0;
            pkt_wc    <= '0;
            pkt_long  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt    <= '0;
            act_start_q <= '0;
            act_end_q   <= '0;
            total_q     <= '0;
            words_q     <= '0;
            hblank_q    <= '0;
            word_cnt    <= '0;
            hblank_cnt  <= '0;
            underflow   <= 1'b0;
        end else begin
            if (state == FRAME_START) begin
                line_cnt    <= '0;
                act_start_q <= cfg_act_start;
                act_end_q   <= cfg_act_end;
                total_q     <= cfg_total;
                words_q     <= cfg_line_words;
                hblank_q    <= cfg_hblank_cycles;
                word_cnt    <= '0;
            end
            if (pld_hs) word_cnt <= last_word ? '0 : word_cnt + 10'd1;
            if (state_nxt == HBLANK && state != HBLANK) begin
                hblank_cnt <= hblank_load;
            end else if (state == HBLANK && !hblank_done) begin
                hblank_cnt <= hblank_cnt - HBLANK_W'(1);
            end
            if (state == HBLANK && hblank_done) line_cnt <= next_line;
            if (state == PAYLOAD && !fifo_not_empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsi_tx_line_scheduler.sv
// Directed bench for dsi_tx_line_scheduler with a show-ahead FIFO model and packet/payload logging.
module tb_dsi_tx_line_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] cfg_vsa_lines, cfg_vbp_lines, cfg_vfp_lines, cfg_vact_lines;
    logic [9:0]  cfg_line_words;
    logic [11:0] cfg_hblank_cycles;
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready;
    logic        fifo_read_ack;
    logic        pkt_valid, pkt_ready;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic        pkt_long;
    logic [31:0] pld_data;
    logic        pld_valid, pld_ready, pld_last;
    logic        frame_active, underflow;

    int n_vec  = 0;
    int n_miss = 0;

    int cyc    = 0;
    int rd_ptr = 0;
    logic starve;

    logic [22:0] pkt_q[$];
    int          pkt_cyc_q[$];
    logic [32:0] pld_q[$];
    int ack_cnt, pld_vcnt, first_valid, en_cyc, base, rel_cyc, n_before;
    logic fa_seen;

    dsi_tx_line_scheduler #(.LINE_CNT_W(12), .HBLANK_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_vsa_lines(cfg_vsa_lines), .cfg_vbp_lines(cfg_vbp_lines),
        .cfg_vfp_lines(cfg_vfp_lines), .cfg_vact_lines(cfg_vact_lines),
        .cfg_line_words(cfg_line_words), .cfg_hblank_cycles(cfg_hblank_cycles),
        .fifo_data(fifo_data), .fifo_not_empty(fifo_not_empty),
        .fifo_line_ready(fifo_line_ready), .fifo_read_ack(fifo_read_ack),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dt(pkt_dt),
        .pkt_wc(pkt_wc), .pkt_long(pkt_long), .pld_data(pld_data),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_last(pld_last),
        .frame_active(frame_active), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (fifo_read_ack) rd_ptr <= rd_ptr + 1;

    assign fifo_data      = 32'hC0DE_0000 + 32'(rd_ptr);
    assign fifo_not_empty = !starve && (rd_ptr < 64);

    always @(negedge clk) begin
        if (pkt_valid && pkt_ready) begin
            pkt_q.push_back({pkt_long, pkt_dt, pkt_wc});
            pkt_cyc_q.push_back(cyc);
        end
        if (pld_valid && pld_ready) pld_q.push_back({pld_last, pld_data});
        if (pld_valid) pld_vcnt++;
        if (fifo_read_ack) ack_cnt++;
        if (pkt_valid && first_valid < 0) first_valid = cyc;
        if (frame_active) fa_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_geom(input int vsa, input int vbp, input int vact, input int vfp,
                            input int words, input int hb);
        cfg_vsa_lines     = 12'(vsa);
        cfg_vbp_lines     = 12'(vbp);
        cfg_vact_lines    = 12'(vact);
        cfg_vfp_lines     = 12'(vfp);
        cfg_line_words    = 10'(words);
        cfg_hblank_cycles = 12'(hb);
    endtask

    task automatic start_frame();
        pkt_q.delete();
        pkt_cyc_q.delete();
        pld_q.delete();
        ack_cnt = 0;
        pld_vcnt = 0;
        first_valid = -1;
        fa_seen = 1'b0;
        @(posedge clk); #1;
        base   = rd_ptr;
        enable = 1'b1;
        en_cyc = cyc;
    endtask

    task automatic wait_pkts(input int n);
        for (int i = 0; i < 300 && pkt_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        if (pkt_q.size() < n) chk("wait_pkts_timeout", 32'(pkt_q.size()), 32'(n));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500 && frame_active; i++) begin
            @(posedge clk); #1;
        end
        if (frame_active) chk("frame_end_timeout", 32'(frame_active), 0);
        n_before = pkt_q.size();
        repeat (6) @(posedge clk);
        #1;
        chk("idle_frame_active", 32'(frame_active), 0);
        chk("idle_no_pkt", 32'(pkt_q.size()), 32'(n_before));
    endtask

    // Geometry 1/1/2/1, 4 words: VSS, HSS, HSS, hdr, HSS, hdr, HSS.
    task automatic check_std_frame();
        logic [22:0] exp_pkt[7];
        exp_pkt[0] = {1'b0, 6'h01, 16'd0};
        exp_pkt[1] = {1'b0, 6'h21, 16'd0};
        exp_pkt[2] = {1'b0, 6'h21, 16'd0};
        exp_pkt[3] = {1'b1, 6'h3E, 16'd16};
        exp_pkt[4] = {1'b0, 6'h21, 16'd0};
        exp_pkt[5] = {1'b1, 6'h3E, 16'd16};
        exp_pkt[6] = {1'b0, 6'h21, 16'd0};
        chk("pkt_count", 32'(pkt_q.size()), 7);
        for (int i = 0; i < 7 && i < pkt_q.size(); i++)
            chk($sformatf("pkt[%0d]", i), 32'(pkt_q[i]), 32'(exp_pkt[i]));
        chk("pld_count", 32'(pld_q.size()), 8);
        for (int i = 0; i < 8 && i < pld_q.size(); i++) begin
            chk($sformatf("pld_data[%0d]", i), pld_q[i][31:0], 32'hC0DE_0000 + 32'(base + i));
            chk($sformatf("pld_last[%0d]", i), 32'(pld_q[i][32]), 32'((i % 4) == 3));
        end
        chk("ack_count", 32'(ack_cnt), 8);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        starve = 1'b0;
        fifo_line_ready = 1'b1;
        pkt_ready = 1'b1;
        pld_ready = 1'b1;
        set_geom(1, 1, 2, 1, 4, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_valid", 32'(pkt_valid), 0);
        chk("rst_pkt_long", 32'(pkt_long), 0);
        chk("rst_pkt_dt", 32'(pkt_dt), 0);
        chk("rst_pkt_wc", 32'(pkt_wc), 0);
        chk("rst_pld_valid", 32'(pld_valid), 0);
        chk("rst_pld_last", 32'(pld_last), 0);
        chk("rst_pld_data", pld_data, 0);
        chk("rst_fifo_read_ack", 32'(fifo_read_ack), 0);
        chk("rst_frame_active", 32'(frame_active), 0);
        chk("rst_underflow", 32'(underflow), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame; enable dropped once line 2 has started.
        start_frame();
        wait_pkts(3);
        enable = 1'b0;
        wait_done();
        check_std_frame();
        chk("t1_latency", 32'(first_valid - en_cyc), 3);
        chk("t1_fa_seen", 32'(fa_seen), 1);
        chk("t1_underflow", 32'(underflow), 0);
        if (pkt_cyc_q.size() == 7) begin
            chk("gap_vss_hss", 32'(pkt_cyc_q[1] - pkt_cyc_q[0]), 5);
            chk("gap_hss_hss", 32'(pkt_cyc_q[2] - pkt_cyc_q[1]), 6);
            chk("gap_hss_hdr", 32'(pkt_cyc_q[3] - pkt_cyc_q[2]), 2);
            chk("gap_hdr_hss", 32'(pkt_cyc_q[4] - pkt_cyc_q[3]), 10);
            chk("gap_hss_hdr2", 32'(pkt_cyc_q[5] - pkt_cyc_q[4]), 2);
            chk("gap_hdr_vfp", 32'(pkt_cyc_q[6] - pkt_cyc_q[5]), 9);
        end else begin
            chk("gap_pkt_count", 32'(pkt_cyc_q.size()), 7);
        end

        // Line not ready for 20 cycles at the first active line.
        fifo_line_ready = 1'b0;
        start_frame();
        wait_pkts(2);
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t2_held_pkts", 32'(pkt_q.size()), 2);
        chk("t2_held_valid", 32'(pkt_valid), 0);
        rel_cyc = cyc;
        fifo_line_ready = 1'b1;
        wait_done();
        check_std_frame();
        if (pkt_cyc_q.size() > 2)
            chk("t2_hss_after_ready", 32'(pkt_cyc_q[2] > rel_cyc), 1);

        // Back-pressure on the long header.
        start_frame();
        wait_pkts(1);
        enable = 1'b0;
        for (int i = 0; i < 300 && !(pkt_valid && pkt_long); i++) begin
            @(posedge clk); #1;
        end
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_stall_valid", 32'(pkt_valid), 1);
            chk("t3_stall_dt", 32'(pkt_dt), 32'h3E);
            chk("t3_stall_wc", 32'(pkt_wc), 16);
        end
        pkt_ready = 1'b1;
        wait_done();
        check_std_frame();
        chk("t3_underflow", 32'(underflow), 0);

        // FIFO runs dry for 3 cycles mid-payload.
        start_frame();
        wait_pkts(1);
        enable = 1'b0;
        for (int i = 0; i < 300 && pld_q.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        starve = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4_starve_valid", 32'(pld_valid), 0);
            chk("t4_starve_ack", 32'(fifo_read_ack), 0);
        end
        starve = 1'b0;
        chk("t4_underflow_set", 32'(underflow), 1);
        wait_done();
        check_std_frame();
        chk("t4_underflow_sticky", 32'(underflow), 1);

        // Zero programming: vsa=0 acts as 1, no payload, single blanking cycle.
        set_geom(0, 0, 1, 0, 0, 0);
        start_frame();
        wait_pkts(1);
        enable = 1'b0;
        wait_done();
        chk("t5_pkt_count", 32'(pkt_q.size()), 3);
        if (pkt_q.size() == 3) begin
            chk("t5_vss", 32'(pkt_q[0]), 32'({1'b0, 6'h01, 16'd0}));
            chk("t5_hss", 32'(pkt_q[1]), 32'({1'b0, 6'h21, 16'd0}));
            chk("t5_hdr", 32'(pkt_q[2]), 32'({1'b1, 6'h3E, 16'd0}));
            chk("t5_gap_blank", 32'(pkt_cyc_q[1] - pkt_cyc_q[0]), 4);
            chk("t5_gap_hdr", 32'(pkt_cyc_q[2] - pkt_cyc_q[1]), 2);
        end
        chk("t5_pld_valid", 32'(pld_vcnt), 0);
        chk("t5_ack", 32'(ack_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
